// File: rtl/debounce_sync_if.sv
// Level-only connection for debounce_sync: raw pin in, debounced level and status out.
// There is no valid/ready handshake here; every signal is a level, sampled each clk edge.
interface debounce_sync_if #(
  parameter int GLITCH_W = 8
);
  logic                a_raw;
  logic                clr_glitch;
  logic                a_clean;
  logic                busy;
  logic [GLITCH_W-1:0] glitch_cnt;
  logic [1:0]          state_dbg;

  modport master (
    output a_raw,
    output clr_glitch,
    input  a_clean,
    input  busy,
    input  glitch_cnt,
    input  state_dbg
  );

  modport slave (
    input  a_raw,
    input  clr_glitch,
    output a_clean,
    output busy,
    output glitch_cnt,
    output state_dbg
  );
endinterface

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a four-state debounce FSM with a saturating
// count of rejected level changes.
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GLITCH_W        = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  debounce_sync_if.slave bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    LOW_WAIT    = 2'd1,
    HIGH_STABLE = 2'd2,
    HIGH_WAIT   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                s1_q, s1_d;
  logic                s2_q, s2_d;
  logic                a_clean_q, a_clean_d;
  logic                busy_q, busy_d;
  logic [GLITCH_W-1:0] glitch_cnt_q, glitch_cnt_d;
  logic                glitch;
  logic                a_sync;

  assign a_sync = s2_q;

  always_comb begin
    s1_d = bus.a_raw;
    s2_d = s1_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_clean_d = a_clean_q;
    glitch    = 1'b0;
    case (state_q)
      LOW_STABLE: begin
        if (a_sync) begin
          state_d = LOW_WAIT;
          cnt_d   = '0;
        end
      end
      LOW_WAIT: begin
        if (!a_sync) begin
          state_d = LOW_STABLE;
          glitch  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = HIGH_STABLE;
          a_clean_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH_STABLE: begin
        if (!a_sync) begin
          state_d = HIGH_WAIT;
          cnt_d   = '0;
        end
      end
      HIGH_WAIT: begin
        if (a_sync) begin
          state_d = HIGH_STABLE;
          glitch  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = LOW_STABLE;
          a_clean_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = LOW_STABLE;
    endcase

    // busy is registered, so it reflects the state being entered this edge
    busy_d = (state_d == LOW_WAIT) || (state_d == HIGH_WAIT);

    // clear takes priority over a coincident glitch; the count sticks at all-ones
    glitch_cnt_d = glitch_cnt_q;
    if (bus.clr_glitch) begin
      glitch_cnt_d = '0;
    end else if (glitch && (glitch_cnt_q != GLITCH_MAX)) begin
      glitch_cnt_d = glitch_cnt_q + GLITCH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      state_q      <= LOW_STABLE;
      cnt_q        <= '0;
      a_clean_q    <= 1'b0;
      busy_q       <= 1'b0;
      glitch_cnt_q <= '0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_clean_q    <= a_clean_d;
      busy_q       <= busy_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign bus.a_clean    = a_clean_q;
  assign bus.busy       = busy_q;
  assign bus.glitch_cnt = glitch_cnt_q;
  assign bus.state_dbg  = state_q;

endmodule
